// File: rtl/csu_dac_controller.sv
// csu_dac_controller
// Power sequencing and code mapping for a segmented current-steering DAC.
// An 11-bit code splits into a 17-unit thermometer segment (code[10:6]) and a
// 6-bit binary LSB segment (code[5:0]). The thermometer segment can rotate its
// start pointer so that unit mismatch is averaged (dynamic element matching).
// A redundant LSB source can stand in for binary source 0.
//
// Handshake: code_valid_i/code_ready_o follow strict valid/ready semantics. A
// code is transferred on a rising clock edge where both are high. code_ready_o
// is high only in ACTIVE while en_i is high, so a power-down request always
// wins over a code offered in the same cycle. Once code_valid_i is raised, its
// code must be held stable until the transfer happens.
module csu_dac_controller #(
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned PWRDN_CYC  = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        code_valid_i,
    input  logic [10:0] code_i,
    output logic        code_ready_o,
    input  logic        dem_en_i,
    input  logic        red_swap_i,
    input  logic [1:0]  atb_sel_i,
    output logic        pdb_o,
    output logic [1:0]  atb_ena_o,
    output logic [16:0] therm_en_o,
    output logic [5:0]  bin_en_o,
    output logic        bin_red_en_o,
    output logic        active_o,
    output logic        code_sat_o,
    output logic [1:0]  dbg_state_o,
    output logic [4:0]  dbg_ptr_o
);

    // Counter reload values; the counter counts down to zero inclusive, so a
    // reload of N-1 gives a phase that lasts exactly N cycles.
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
    localparam logic [7:0] PWRDN_LOAD  = 8'(PWRDN_CYC - 1);
    localparam int unsigned NUM_UNITS  = 17;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_PWRUP  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_PWRDN  = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  ptr_q;
    logic        pdb_q;
    logic [1:0]  atb_q;
    logic [16:0] therm_q;
    logic [5:0]  bin_q;
    logic        bin_red_q;
    logic        sat_q;

    // Decoded view of the offered code, used only when it is accepted
    logic        take_code;
    logic [4:0]  therm_raw;
    logic        therm_over;
    logic [4:0]  therm_n;
    logic [4:0]  start_ptr;
    logic [17:0] run_mask_w;
    logic [16:0] run_mask;
    logic [33:0] run_rot;
    logic [16:0] therm_d;
    logic [5:0]  ptr_sum;
    logic [5:0]  ptr_wrap;
    logic [4:0]  ptr_d;
    logic [5:0]  bin_d;
    logic        bin_red_d;

    // Code decode: clamp the unit count, build a contiguous run of N ones and
    // rotate it (mod 17) to start at the current pointer.
    always_comb begin
        take_code  = (state_q == ST_ACTIVE) && en_i && code_valid_i;
        therm_raw  = code_i[10:6];
        therm_over = (therm_raw > 5'd17);
        therm_n    = therm_over ? 5'd17 : therm_raw;
        start_ptr  = dem_en_i ? ptr_q : 5'd0;

        // (1 << N) - 1 gives N low ones; N = 17 yields all 17 bits set.
        run_mask_w = (18'd1 << therm_n) - 18'd1;
        run_mask   = run_mask_w[16:0];

        // Rotate within 17 bits: shift into a double-width word and fold the
        // overflow half back onto bit 0.
        run_rot    = {17'd0, run_mask} << start_ptr;
        therm_d    = run_rot[16:0] | run_rot[33:17];

        // Next pointer: (ptr + N) mod 17. Both operands are at most 17, so a
        // single conditional subtraction is enough.
        ptr_sum    = {1'b0, ptr_q} + {1'b0, therm_n};
        ptr_wrap   = (ptr_sum >= 6'(NUM_UNITS)) ? (ptr_sum - 6'(NUM_UNITS)) : ptr_sum;
        ptr_d      = dem_en_i ? ptr_wrap[4:0] : ptr_q;

        // Redundant LSB source takes the place of binary source 0.
        if (red_swap_i) begin
            bin_d     = {code_i[5:1], 1'b0};
            bin_red_d = code_i[0];
        end else begin
            bin_d     = code_i[5:0];
            bin_red_d = 1'b0;
        end
    end

    // Sequencer FSM with registered array controls; code_sat is a single-cycle
    // pulse so it defaults low every cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            cnt_q     <= 8'd0;
            ptr_q     <= 5'd0;
            pdb_q     <= 1'b0;
            therm_q   <= 17'd0;
            bin_q     <= 6'd0;
            bin_red_q <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            sat_q <= 1'b0;
            case (state_q)
                ST_OFF: begin
                    pdb_q     <= 1'b0;
                    therm_q   <= 17'd0;
                    bin_q     <= 6'd0;
                    bin_red_q <= 1'b0;
                    if (en_i) begin
                        state_q <= ST_PWRUP;
                        pdb_q   <= 1'b1;
                        cnt_q   <= SETTLE_LOAD;
                    end
                end

                ST_PWRUP: begin
                    // Array is biased but unit enables stay off while it settles.
                    therm_q   <= 17'd0;
                    bin_q     <= 6'd0;
                    bin_red_q <= 1'b0;
                    if (!en_i) begin
                        state_q <= ST_PWRDN;
                        cnt_q   <= PWRDN_LOAD;
                    end else if (cnt_q == 8'd0) begin
                        state_q <= ST_ACTIVE;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                ST_ACTIVE: begin
                    if (!en_i) begin
                        state_q   <= ST_PWRDN;
                        cnt_q     <= PWRDN_LOAD;
                        therm_q   <= 17'd0;
                        bin_q     <= 6'd0;
                        bin_red_q <= 1'b0;
                    end else if (take_code) begin
                        therm_q   <= therm_d;
                        bin_q     <= bin_d;
                        bin_red_q <= bin_red_d;
                        sat_q     <= therm_over;
                        ptr_q     <= ptr_d;
                    end
                end

                ST_PWRDN: begin
                    // Requests to power up are ignored until OFF is reached.
                    therm_q   <= 17'd0;
                    bin_q     <= 6'd0;
                    bin_red_q <= 1'b0;
                    if (cnt_q == 8'd0) begin
                        state_q <= ST_OFF;
                        pdb_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                default: begin
                    state_q <= ST_OFF;
                    pdb_q   <= 1'b0;
                end
            endcase
        end
    end

    // Testbus selection register; gated off at the output whenever pdb is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            atb_q <= 2'b00;
        end else begin
            atb_q <= atb_sel_i;
        end
    end

    assign code_ready_o = (state_q == ST_ACTIVE) && en_i;
    assign active_o     = (state_q == ST_ACTIVE);
    assign pdb_o        = pdb_q;
    assign atb_ena_o    = pdb_q ? atb_q : 2'b00;
    assign therm_en_o   = therm_q;
    assign bin_en_o     = bin_q;
    assign bin_red_en_o = bin_red_q;
    assign code_sat_o   = sat_q;
    assign dbg_state_o  = state_q;
    assign dbg_ptr_o    = ptr_q;

endmodule

// File: tb/tb_csu_dac_controller.sv
// Testbench for csu_dac_controller: directed sequencing checks plus randomized
// code traffic checked through an expected-response queue.
module tb_csu_dac_controller;

    localparam int SETTLE_CYC = 64;
    localparam int PWRDN_CYC  = 4;

    logic        clk;
    logic        rst;
    logic        en;
    logic        code_valid;
    logic [10:0] code;
    logic        code_ready;
    logic        dem_en;
    logic        red_swap;
    logic [1:0]  atb_sel;
    logic        pdb;
    logic [1:0]  atb_ena;
    logic [16:0] therm_en;
    logic [5:0]  bin_en;
    logic        bin_red_en;
    logic        active;
    logic        code_sat;
    logic [1:0]  dbg_state;
    logic [4:0]  dbg_ptr;

    int checks = 0;
    int errors = 0;

    // Expected response: {therm[16:0], bin[5:0], bin_red, sat}
    logic [24:0] exp_q[$];
    int          model_ptr = 0;
    logic        acc_seen = 1'b0;

    csu_dac_controller #(.SETTLE_CYC(SETTLE_CYC), .PWRDN_CYC(PWRDN_CYC)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .en_i         (en),
        .code_valid_i (code_valid),
        .code_i       (code),
        .code_ready_o (code_ready),
        .dem_en_i     (dem_en),
        .red_swap_i   (red_swap),
        .atb_sel_i    (atb_sel),
        .pdb_o        (pdb),
        .atb_ena_o    (atb_ena),
        .therm_en_o   (therm_en),
        .bin_en_o     (bin_en),
        .bin_red_en_o (bin_red_en),
        .active_o     (active),
        .code_sat_o   (code_sat),
        .dbg_state_o  (dbg_state),
        .dbg_ptr_o    (dbg_ptr)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Thermometer: N units starting at the pointer, wrapping modulo 17.
    function automatic logic [24:0] model_code(input logic [10:0] c, input logic dem,
                                                input logic red, inout int ptr);
        int          n;
        int          start;
        logic        sat;
        logic [16:0] th;
        logic [5:0]  b;
        logic        r;
        n     = int'(c[10:6]);
        sat   = (n > 17);
        if (sat) n = 17;
        start = dem ? ptr : 0;
        th    = '0;
        for (int k = 0; k < n; k++) th[(start + k) % 17] = 1'b1;
        if (red) begin
            b = c[5:0] & 6'b111110;
            r = c[0];
        end else begin
            b = c[5:0];
            r = 1'b0;
        end
        if (dem) ptr = (ptr + n) % 17;
        return {th, b, r, sat};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [10:0] c, input logic dem, input logic red);
        code       = c;
        dem_en     = dem;
        red_swap   = red;
        code_valid = 1'b1;
        #1;
        check("code_ready_active", code_ready, 1'b1);
        exp_q.push_back(model_code(c, dem, red, model_ptr));
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    // Called at a negedge; raises en and measures the settle interval.
    task automatic bring_up();
        int   cycles;
        logic en_leak;
        en = 1'b1;
        @(negedge clk);
        check("pdb_rise", pdb, 1'b1);
        check("atb_follow_pwrup", atb_ena, atb_sel);
        cycles  = 0;
        en_leak = 1'b0;
        while (!active && cycles < 300) begin
            if (therm_en != 0 || bin_en != 0 || bin_red_en || code_ready) en_leak = 1'b1;
            @(negedge clk);
            cycles++;
        end
        check("settle_cycles", cycles, SETTLE_CYC);
        check("enables_off_pwrup", en_leak, 1'b0);
    endtask

    // Called at a negedge with en already low; waits for pdb to fall.
    task automatic wait_pdb_low(output int cycles);
        cycles = 0;
        while (pdb && cycles < 50) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) acc_seen <= code_valid && code_ready && !rst;

    always @(negedge clk) begin
        logic [24:0] e;
        if (acc_seen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_accept", 1'b1, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("therm_en", therm_en, e[24:8]);
                check("bin_en", bin_en, e[7:2]);
                check("bin_red_en", bin_red_en, e[1]);
                check("code_sat", code_sat, e[0]);
            end
        end else begin
            check("code_sat_idle", code_sat, 1'b0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int cyc;
        rst        = 1'b0;
        en         = 1'b0;
        code_valid = 1'b0;
        code       = '0;
        dem_en     = 1'b0;
        red_swap   = 1'b0;
        atb_sel    = 2'b11;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);

        // Reset values
        check("rst_state", dbg_state, 2'd0);
        check("rst_ptr", dbg_ptr, 5'd0);
        check("rst_pdb", pdb, 1'b0);
        check("rst_atb", atb_ena, 2'b00);
        check("rst_therm", therm_en, 17'd0);
        check("rst_bin", {bin_en, bin_red_en}, 7'd0);
        check("rst_ready", code_ready, 1'b0);
        check("rst_active", active, 1'b0);

        rst     = 1'b0;
        atb_sel = 2'b01;
        bring_up();

        // Two identical codes with rotation: N=3 then next 3 units
        send(11'h0C5, 1'b1, 1'b0);
        check("therm_first_c5", therm_en, 17'h00007);
        check("bin_first_c5", bin_en, 6'b000101);
        send(11'h0C5, 1'b1, 1'b0);
        check("therm_second_c5", therm_en, 17'h00038);

        // Walk pointer to 15, then wrap with N=4
        send(11'h240, 1'b1, 1'b0);
        check("ptr_15", dbg_ptr, 5'd15);
        send(11'h100, 1'b1, 1'b0);
        check("therm_wrap", therm_en, 17'h18003);
        check("ptr_wrap", dbg_ptr, 5'd2);

        // Saturation and redundant LSB swap; fixed start leaves ptr alone
        send(11'h7FF, 1'b0, 1'b0);
        check("therm_full", therm_en, 17'h1FFFF);
        check("ptr_hold_dem0", dbg_ptr, 5'd2);
        send(11'h001, 1'b0, 1'b1);
        check("red_swap_lsb", {bin_en, bin_red_en}, 7'b0000001);

        // Randomized traffic with idle gaps
        for (int i = 0; i < 150; i++) begin
            atb_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                send(11'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
            end else begin
                @(negedge clk);
            end
        end
        check("atb_active", atb_ena, atb_sel);

        // Power down with a simultaneous code offer
        atb_sel    = 2'b10;
        @(negedge clk);
        en         = 1'b0;
        code_valid = 1'b1;
        code       = 11'h3C3;
        #1;
        check("ready_low_on_pwrdn", code_ready, 1'b0);
        @(negedge clk);
        code_valid = 1'b0;
        check("pwrdn_state", dbg_state, 2'd3);
        check("pwrdn_enables", {therm_en, bin_en, bin_red_en}, 24'd0);
        check("pwrdn_active", active, 1'b0);
        check("pwrdn_pdb_held", pdb, 1'b1);
        check("pwrdn_atb", atb_ena, 2'b10);
        // en raised mid power-down must not shorten or abort it
        cyc = 0;
        @(negedge clk);
        cyc++;
        en = 1'b1;
        while (pdb && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("pwrdn_cycles", cyc, PWRDN_CYC);
        check("off_atb", atb_ena, 2'b00);
        check("off_state", dbg_state, 2'd0);

        // Pointer survives the power cycle
        bring_up();
        check("ptr_preserved", dbg_ptr, 5'(model_ptr));
        send(11'h0C5, 1'b1, 1'b0);
        send(11'h4AA, 1'b1, 1'b1);

        // Reset in the middle of power-up
        en = 1'b0;
        @(negedge clk);
        wait_pdb_low(cyc);
        check("second_pwrdn_cycles", cyc, PWRDN_CYC);
        atb_sel = 2'b11;
        en      = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_pwrup_state", dbg_state, 2'd1);
        check("mid_pwrup_atb", atb_ena, 2'b11);
        #2 rst = 1'b1;
        #1;
        check("async_rst_state", dbg_state, 2'd0);
        check("async_rst_pdb", pdb, 1'b0);
        check("async_rst_atb", atb_ena, 2'b00);
        check("async_rst_ptr", dbg_ptr, 5'd0);
        check("async_rst_outs", {therm_en, bin_en, bin_red_en, code_ready, active, code_sat}, 27'd0);
        model_ptr = 0;
        en        = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("wait_in_off", {dbg_state, pdb}, 3'b000);

        // After reset the pointer restarts at unit 0
        bring_up();
        send(11'h0C5, 1'b1, 1'b0);
        check("therm_after_rst", therm_en, 17'h00007);
        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/csu_dac_controller.md
CSU_DAC_CONTROLLER -- requirements
Module: csu_dac_controller

Interface
REQ-001 SETTLE_CYC, default 64, number of clock cycles pdb is held high before unit enables are allowed (1..255).
REQ-002 PWRDN_CYC, default 4, number of clock cycles between clearing enables and dropping pdb (1..255).
REQ-003 clk  in  1  single block clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  level request: 1 = bring current source array up, 0 = take it down.
REQ-006 code_valid  in  1  new DAC code offered.
REQ-007 code  in  11  code[10:6] = thermometer unit count, code[5:0] = binary LSB field.
REQ-008 code_ready  out  1  controller accepts code this cycle.
REQ-009 dem_en  in  1  1 = rotate the thermometer start pointer (dynamic element matching), 0 = fixed start at unit 0.
REQ-010 red_swap  in  1  1 = redundant LSB source replaces binary source 0.
REQ-011 atb_sel  in  2  requested analog testbus selection.
REQ-012 pdb  out  1  power-down-negate to current source array.
REQ-013 atb_ena  out  2  testbus selection to current source array.
REQ-014 therm_en  out  17  per-unit enables, thermometer units 16..0.
REQ-015 bin_en  out  6  binary unit enables, bit i weights 2^i LSB.
REQ-016 bin_red_en  out  1  redundant LSB unit enable.
REQ-017 active  out  1  high only in state ACTIVE.
REQ-018 code_sat  out  1  one-cycle pulse when an accepted code was clamped.

Function
REQ-019 FSM states: OFF, PWRUP, ACTIVE, PWRDN; one 8-bit down-counter cnt shared by PWRUP and PWRDN.
REQ-020 OFF: pdb=0, all enables 0; en=1 -> PWRUP, pdb=1 from next cycle, cnt loaded SETTLE_CYC-1.
REQ-021 PWRUP: enables held 0, code_ready=0; cnt decrements each cycle; cnt==0 -> ACTIVE; en=0 at any time -> PWRDN (cnt loaded PWRDN_CYC-1).
REQ-022 ACTIVE: code_ready=1; code accepted on code_valid&&code_ready; enable outputs reflect accepted code one cycle later and hold until next acceptance.
REQ-023 Thermometer count N = min(code[10:6], 17); code[10:6] > 17 sets code_sat for one cycle, same latency as enables.
REQ-024 therm_en bits ptr, ptr+1, ..., ptr+N-1 (mod 17) are 1, all others 0; N=0 -> all 0; N=17 -> all 1.
REQ-025 ptr is 5 bits, range 0..16; on acceptance with dem_en=1, ptr <= (ptr+N) mod 17; dem_en=0 forces ptr usage of 0 and holds ptr unchanged.
REQ-026 red_swap=0: bin_en = code[5:0], bin_red_en=0; red_swap=1: bin_en[5:1] = code[5:1], bin_en[0]=0, bin_red_en = code[0]; red_swap sampled at acceptance.
REQ-027 ACTIVE with en=0 -> PWRDN; en has priority over a simultaneous code_valid (code not accepted, code_ready=0 that cycle).
REQ-028 PWRDN: all enables cleared on entry cycle, code_ready=0, pdb stays 1; cnt==0 -> OFF with pdb=0; en=1 during PWRDN is ignored until OFF is reached.
REQ-029 atb_ena = registered atb_sel (1-cycle latency) while pdb=1; forced 00 while pdb=0.
REQ-030 ptr is preserved across PWRDN/OFF cycles; only rst clears it.

Reset
REQ-031 rst=1 asynchronously forces: state OFF, cnt 0, ptr 0, pdb 0, atb_ena 00, therm_en 0, bin_en 0, bin_red_en 0, code_ready 0, active 0, code_sat 0.
REQ-032 rst asserted mid-PWRUP or mid-ACTIVE takes effect immediately without passing through PWRDN; after release the block waits in OFF for en.

Verification
REQ-033 rst release, en=1, SETTLE_CYC=64 -> pdb=1 one cycle later, active=1 exactly 64 cycles after pdb rises, enables 0 throughout PWRUP.
REQ-034 ACTIVE, dem_en=1, codes 0x0C5 then 0x0C5 (N=3, LSB=5) -> therm_en=0x00007 then 0x00038, bin_en=000101 each.
REQ-035 ptr=15, dem_en=1, N=4 -> therm_en bits 15,16,0,1 set (0x18003), ptr becomes 2.
REQ-036 code 0x7FF -> therm_en=0x1FFFF, bin_en=111111, code_sat pulse 1 cycle; red_swap=1 with code 0x001 -> bin_en=0, bin_red_en=1.
REQ-037 ACTIVE, en=0 with simultaneous code_valid -> code_ready=0, enables 0 next cycle, pdb falls after PWRDN_CYC cycles, atb_ena 00 with pdb.
REQ-038 rst pulse mid-PWRUP with atb_sel=11 -> all outputs at reset values immediately, atb_ena 00, ptr 0.
